// File: rtl/gbf_fill_controller_pkg.sv
// Shared definitions for the GBF fill controller: FSM encoding and the
// mapping from (channel, bank) to the flat bank index used on every bus.
package gbf_fill_controller_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ARB  = 3'd1;
    localparam logic [2:0] ST_REQ  = 3'd2;
    localparam logic [2:0] ST_FILL = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    // bank 0 = bank1, bank 1 = bank2 of the channel
    function automatic int bank_idx(input int ch, input int bank);
        return 2 * ch + bank;
    endfunction

endpackage

// File: rtl/gbf_fill_controller_rr_arbiter.sv
// Round-robin arbiter: the search starts one past the last accepted index,
// so every requester is reached within WIDTH grants.
module rr_arbiter #(
    parameter int WIDTH = 4,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [WIDTH-1:0] req,
    input  logic             accept,
    output logic [WIDTH-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

    logic [IDX_W-1:0] last_idx;
    int               cand_idx;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand_idx    = 0;
        for (int i = 0; i < WIDTH; i++) begin
            cand_idx = int'(last_idx) + 1 + i;
            if (cand_idx >= WIDTH) cand_idx = cand_idx - WIDTH;
            if (!grant_valid && req[cand_idx]) begin
                grant_valid      = 1'b1;
                grant_idx        = IDX_W'(cand_idx);
                grant[cand_idx]  = 1'b1;
            end
        end
    end

    // Pointer starts at the top index so the first search begins at 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_idx <= IDX_W'(WIDTH - 1);
        end else if (clear) begin
            last_idx <= IDX_W'(WIDTH - 1);
        end else if (accept && grant_valid) begin
            last_idx <= grant_idx;
        end
    end

endmodule

// File: rtl/gbf_fill_controller.sv
// Loads the double-buffered GBF banks from an off-chip stream: arbitrates the
// per-bank need_data requests, issues a fetch, writes the burst, flags ready.
module gbf_fill_controller
    import gbf_fill_controller_pkg::*;
#(
    parameter int NUM_CH            = 2,
    parameter int GBF_DATA_BITWIDTH = 256,
    parameter int GBF_ADDR_BITWIDTH = 5,
    parameter int GBF_DEPTH         = 32,
    parameter int CH_BITWIDTH       = 1,
    parameter int TILE_BITWIDTH     = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [GBF_ADDR_BITWIDTH:0]     cfg_burst_len,
    input  logic [TILE_BITWIDTH-1:0]       cfg_num_tiles,
    input  logic [2*NUM_CH-1:0]            need_data,
    output logic                           fetch_req,
    output logic [CH_BITWIDTH-1:0]         fetch_ch,
    output logic                           fetch_bank,
    output logic [GBF_ADDR_BITWIDTH:0]     fetch_len,
    input  logic                           fetch_ack,
    input  logic                           in_valid,
    input  logic [GBF_DATA_BITWIDTH-1:0]   in_data,
    output logic                           in_ready,
    output logic [2*NUM_CH-1:0]            gbf_en,
    output logic [2*NUM_CH-1:0]            gbf_we,
    output logic [GBF_ADDR_BITWIDTH-1:0]   gbf_addr,
    output logic [GBF_DATA_BITWIDTH-1:0]   gbf_w_data,
    output logic [2*NUM_CH-1:0]            buf_ready,
    output logic [NUM_CH-1:0]              data_avail,
    output logic                           finish
);

    localparam int NB    = 2 * NUM_CH;
    localparam int IDX_W = CH_BITWIDTH + 1;
    localparam int LEN_W = GBF_ADDR_BITWIDTH + 1;

    logic [2:0]               state;
    logic [IDX_W-1:0]         grant_q;
    logic [NB-1:0]            grant_oh_q;
    logic [LEN_W-1:0]         len_q;
    logic [LEN_W-1:0]         word_cnt;
    logic [TILE_BITWIDTH-1:0] num_tiles_q;
    logic [TILE_BITWIDTH-1:0] tiles_done [NUM_CH];
    logic [NB-1:0]            need_q;
    logic [NB-1:0]            buf_ready_q;
    logic                     finish_q;

    logic [NB-1:0]            cand;
    logic [NB-1:0]            arb_grant;
    logic [IDX_W-1:0]         arb_idx;
    logic                     arb_valid;
    logic [CH_BITWIDTH-1:0]   grant_ch;
    logic                     all_done;
    logic                     done_after;
    logic                     wr;
    logic                     last_word;
    logic [NB-1:0]            set_mask;
    logic [NB-1:0]            clr_mask;

    assign grant_ch  = grant_q[IDX_W-1:1];
    assign wr        = in_valid && (state == ST_FILL);
    assign last_word = (word_cnt == len_q - LEN_W'(1));
    assign set_mask  = (state == ST_DONE) ? grant_oh_q : '0;
    assign clr_mask  = need_data & ~need_q;

    // done_after looks one DONE ahead: the granted channel counts its current fill.
    always_comb begin
        cand       = '0;
        all_done   = 1'b1;
        done_after = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
            for (int b = 0; b < 2; b++) begin
                cand[bank_idx(c, b)] = need_q[bank_idx(c, b)] & ~buf_ready_q[bank_idx(c, b)]
                                       & (tiles_done[c] < num_tiles_q);
            end
            if (tiles_done[c] != num_tiles_q) all_done = 1'b0;
            if (CH_BITWIDTH'(c) == grant_ch) begin
                if (tiles_done[c] + TILE_BITWIDTH'(1) != num_tiles_q) done_after = 1'b0;
            end else if (tiles_done[c] != num_tiles_q) begin
                done_after = 1'b0;
            end
        end
    end

    rr_arbiter #(
        .WIDTH (NB),
        .IDX_W (IDX_W)
    ) u_arb (
        .clk         (clk),
        .reset       (reset),
        .clear       (start && (state == ST_IDLE)),
        .req         (cand),
        .accept      ((state == ST_ARB) && !all_done),
        .grant       (arb_grant),
        .grant_idx   (arb_idx),
        .grant_valid (arb_valid)
    );

    // A DONE set for a bank overrides a same-cycle clear from its need_data edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            grant_q     <= '0;
            grant_oh_q  <= '0;
            len_q       <= '0;
            word_cnt    <= '0;
            num_tiles_q <= '0;
            need_q      <= '0;
            buf_ready_q <= '0;
            finish_q    <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) tiles_done[c] <= '0;
        end else begin
            need_q      <= need_data;
            buf_ready_q <= (buf_ready_q & ~clr_mask) | set_mask;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state       <= ST_ARB;
                        len_q       <= (cfg_burst_len == '0) ? LEN_W'(GBF_DEPTH) : cfg_burst_len;
                        num_tiles_q <= cfg_num_tiles;
                        finish_q    <= (cfg_num_tiles == '0);
                        for (int c = 0; c < NUM_CH; c++) tiles_done[c] <= '0;
                    end
                end
                ST_ARB: begin
                    if (all_done) begin
                        finish_q <= 1'b1;
                        state    <= ST_IDLE;
                    end else if (arb_valid) begin
                        grant_q    <= arb_idx;
                        grant_oh_q <= arb_grant;
                        state      <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (fetch_ack) begin
                        word_cnt <= '0;
                        state    <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (wr) begin
                        word_cnt <= word_cnt + LEN_W'(1);
                        if (last_word) state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    tiles_done[grant_ch] <= tiles_done[grant_ch] + TILE_BITWIDTH'(1);
                    if (done_after) begin
                        finish_q <= 1'b1;
                        state    <= ST_IDLE;
                    end else begin
                        state <= ST_ARB;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign fetch_req  = (state == ST_REQ);
    assign fetch_ch   = fetch_req ? grant_ch : '0;
    assign fetch_bank = fetch_req & grant_q[0];
    assign fetch_len  = len_q;
    assign in_ready   = (state == ST_FILL);
    assign gbf_en     = wr ? grant_oh_q : '0;
    assign gbf_we     = gbf_en;
    assign gbf_addr   = wr ? word_cnt[GBF_ADDR_BITWIDTH-1:0] : '0;
    assign gbf_w_data = wr ? in_data : '0;
    assign buf_ready  = buf_ready_q;
    assign finish     = finish_q;

    always_comb begin
        data_avail = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            data_avail[c] = buf_ready_q[bank_idx(c, 0)] | buf_ready_q[bank_idx(c, 1)];
        end
    end

endmodule

// File: tb/tb_gbf_fill_controller.sv
// Scoreboard bench for gbf_fill_controller: directed fills push expected writes
// and fetches into queues, a negedge monitor pops and compares them.
module tb_gbf_fill_controller;

    localparam int NUM_CH = 2;
    localparam int DW     = 256;
    localparam int AW     = 5;
    localparam int CHW    = 1;
    localparam int TW     = 16;
    localparam int NB     = 2 * NUM_CH;
    localparam int LW     = AW + 1;

    typedef struct packed {
        logic [NB-1:0] en;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct packed {
        logic [CHW-1:0] ch;
        logic           bank;
        logic [LW-1:0]  len;
    } fe_t;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           start = 1'b0;
    logic [LW-1:0]  cfg_burst_len = '0;
    logic [TW-1:0]  cfg_num_tiles = '0;
    logic [NB-1:0]  need_data = '0;
    logic           fetch_req;
    logic [CHW-1:0] fetch_ch;
    logic           fetch_bank;
    logic [LW-1:0]  fetch_len;
    logic           fetch_ack = 1'b0;
    logic           in_valid = 1'b0;
    logic [DW-1:0]  in_data = '0;
    logic           in_ready;
    logic [NB-1:0]  gbf_en;
    logic [NB-1:0]  gbf_we;
    logic [AW-1:0]  gbf_addr;
    logic [DW-1:0]  gbf_w_data;
    logic [NB-1:0]  buf_ready;
    logic [NUM_CH-1:0] data_avail;
    logic           finish;

    wr_t exp_wr[$];
    fe_t exp_fe[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    gbf_fill_controller #(
        .NUM_CH            (NUM_CH),
        .GBF_DATA_BITWIDTH (DW),
        .GBF_ADDR_BITWIDTH (AW),
        .GBF_DEPTH         (32),
        .CH_BITWIDTH       (CHW),
        .TILE_BITWIDTH     (TW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .cfg_burst_len (cfg_burst_len),
        .cfg_num_tiles (cfg_num_tiles),
        .need_data     (need_data),
        .fetch_req     (fetch_req),
        .fetch_ch      (fetch_ch),
        .fetch_bank    (fetch_bank),
        .fetch_len     (fetch_len),
        .fetch_ack     (fetch_ack),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .gbf_en        (gbf_en),
        .gbf_we        (gbf_we),
        .gbf_addr      (gbf_addr),
        .gbf_w_data    (gbf_w_data),
        .buf_ready     (buf_ready),
        .data_avail    (data_avail),
        .finish        (finish)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] mkData(input int b, input int k);
        logic [31:0] w;
        w = 32'hC0DE_0000 ^ 32'(b * 256 + k);
        return {8{w}};
    endfunction

    // Pulses start for one cycle with the given configuration.
    task automatic applyStimulus(input int burst, input int tiles);
        cfg_burst_len = LW'(burst);
        cfg_num_tiles = TW'(tiles);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic doReset();
        in_valid  = 1'b0;
        fetch_ack = 1'b0;
        reset     = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    // Waits for fetch_req (bounded), optionally holds ack low, then acks one cycle.
    task automatic doFetch(input int ch, input int bank, input int len, input int hold, output int lat);
        fe_t f;
        f.ch   = CHW'(ch);
        f.bank = bank[0];
        f.len  = LW'(len);
        exp_fe.push_back(f);
        lat = 0;
        while (!fetch_req && lat < 50) begin
            tick();
            lat++;
        end
        if (!fetch_req) begin
            checkOutput("fetch_req_timeout", DW'(fetch_req), DW'(1));
            return;
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checkOutput("hold_stable", DW'({fetch_req, fetch_ch, fetch_bank, fetch_len, gbf_en, in_ready}),
                        DW'({1'b1, f.ch, f.bank, f.len, NB'(0), 1'b0}));
            tick();
        end
        fetch_ack = 1'b1;
        tick();
        fetch_ack = 1'b0;
    endtask

    // Streams n words into bank bidx; with gaps, an idle cycle precedes each word after the first.
    task automatic streamWords(input int bidx, input int n, input bit gaps);
        int  guard;
        wr_t w;
        for (int k = 0; k < n; k++) begin
            if (gaps && k > 0) begin
                in_valid = 1'b0;
                @(negedge clk);
                checkOutput("gap_en", DW'(gbf_en), '0);
                tick();
            end
            w.en   = NB'(1) << bidx;
            w.addr = AW'(k);
            w.data = mkData(bidx, k);
            exp_wr.push_back(w);
            in_valid = 1'b1;
            in_data  = w.data;
            guard    = 0;
            @(negedge clk);
            while (!in_ready && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            if (!in_ready) checkOutput("in_ready_timeout", DW'(in_ready), DW'(1));
            tick();
        end
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    // Monitor: every GBF write and every accepted fetch is matched against the queues.
    always @(negedge clk) begin
        wr_t w;
        fe_t f;
        if (!reset) begin
            if (gbf_en != '0 || gbf_we != '0) begin
                if (exp_wr.size() == 0) begin
                    checkOutput("unexpected_write", DW'(gbf_en), '0);
                end else begin
                    w = exp_wr.pop_front();
                    checkOutput("wr_en",   DW'(gbf_en),   DW'(w.en));
                    checkOutput("wr_we",   DW'(gbf_we),   DW'(w.en));
                    checkOutput("wr_addr", DW'(gbf_addr), DW'(w.addr));
                    checkOutput("wr_data", gbf_w_data,    w.data);
                end
            end
            if (fetch_req && fetch_ack) begin
                if (exp_fe.size() == 0) begin
                    checkOutput("unexpected_fetch", DW'(fetch_req), '0);
                end else begin
                    f = exp_fe.pop_front();
                    checkOutput("fetch_ch",   DW'(fetch_ch),   DW'(f.ch));
                    checkOutput("fetch_bank", DW'(fetch_bank), DW'(f.bank));
                    checkOutput("fetch_len",  DW'(fetch_len),  DW'(f.len));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        int req_cycles;

        // Reset state
        #1;
        checkOutput("rst_fetch_req", DW'(fetch_req), '0);
        checkOutput("rst_in_ready",  DW'(in_ready),  '0);
        checkOutput("rst_gbf_en",    DW'(gbf_en),    '0);
        checkOutput("rst_buf_ready", DW'(buf_ready), '0);
        checkOutput("rst_finish",    DW'(finish),    '0);
        doReset();

        // Single fill of channel 0 bank1, burst 4
        applyStimulus(4, 1);
        need_data = 4'b0001;
        doFetch(0, 0, 4, 0, lat);
        checkOutput("need_to_req_latency", DW'(lat), DW'(2));
        streamWords(0, 4, 1'b0);
        checkOutput("br_before_done", DW'(buf_ready), '0);
        tick();
        checkOutput("br_after_done", DW'(buf_ready), DW'(4'b0001));
        checkOutput("data_avail", DW'(data_avail), DW'(2'b01));
        checkOutput("no_finish_partial", DW'(finish), '0);

        // Reset in the middle of a burst, then refill from address 0
        doReset();
        applyStimulus(8, 1);
        doFetch(0, 0, 8, 0, lat);
        streamWords(0, 3, 1'b0);
        in_valid = 1'b1;
        in_data  = mkData(9, 9);
        reset    = 1'b1;
        #1;
        checkOutput("midrst_gbf_en",    DW'(gbf_en),    '0);
        checkOutput("midrst_in_ready",  DW'(in_ready),  '0);
        checkOutput("midrst_buf_ready", DW'(buf_ready), '0);
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        tick();
        applyStimulus(8, 1);
        doFetch(0, 0, 8, 0, lat);
        streamWords(0, 8, 1'b0);
        checkOutput("refill_br_before", DW'(buf_ready), '0);
        tick();
        checkOutput("refill_br_after", DW'(buf_ready), DW'(4'b0001));

        // All four banks request together: round-robin 0,1,2,3 then finish
        need_data = '0;
        doReset();
        applyStimulus(2, 2);
        need_data = 4'b1111;
        for (int b = 0; b < 4; b++) begin
            doFetch(b / 2, b % 2, 2, 0, lat);
            streamWords(b, 2, 1'b0);
            checkOutput("rr_finish_pending", DW'(finish), '0);
            tick();
        end
        checkOutput("rr_finish", DW'(finish), DW'(1));
        checkOutput("rr_buf_ready", DW'(buf_ready), DW'(4'b1111));
        checkOutput("rr_data_avail", DW'(data_avail), DW'(2'b11));
        applyStimulus(2, 1);
        checkOutput("start_clears_finish", DW'(finish), '0);

        // Ack held low 10 cycles, then a gapped 8-word burst into channel 1 bank1
        need_data = '0;
        doReset();
        applyStimulus(8, 1);
        need_data = 4'b0100;
        doFetch(1, 0, 8, 10, lat);
        streamWords(2, 8, 1'b1);
        tick();
        checkOutput("gap_buf_ready", DW'(buf_ready), DW'(4'b0100));

        // buf_ready cleared by a new need_data rise, then refilled
        need_data = '0;
        doReset();
        applyStimulus(2, 3);
        need_data = 4'b0010;
        doFetch(0, 1, 2, 0, lat);
        streamWords(1, 2, 1'b0);
        tick();
        checkOutput("b1_ready", DW'(buf_ready), DW'(4'b0010));
        need_data = '0;
        tick();
        tick();
        checkOutput("b1_fall_keeps", DW'(buf_ready), DW'(4'b0010));
        need_data = 4'b0010;
        tick();
        checkOutput("b1_rise_clears", DW'(buf_ready), '0);
        doFetch(0, 1, 2, 0, lat);
        streamWords(1, 2, 1'b0);
        tick();
        checkOutput("b1_refilled", DW'(buf_ready), DW'(4'b0010));
        applyStimulus(4, 0);
        checkOutput("start_ignored_busy", DW'(finish), '0);

        // Zero tiles: finish right after start, no fetch activity
        need_data = '0;
        doReset();
        need_data = 4'b1111;
        applyStimulus(4, 0);
        checkOutput("zero_tiles_finish", DW'(finish), DW'(1));
        req_cycles = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (fetch_req) req_cycles++;
        end
        checkOutput("zero_tiles_no_req", DW'(req_cycles), '0);

        tick();
        checkOutput("wr_queue_drained", DW'(exp_wr.size()), '0);
        checkOutput("fe_queue_drained", DW'(exp_fe.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
